// File: rtl/core_out_pkg.sv
// core_out_pkg: shared FSM states and return-source encodings for the output arbiter
package core_out_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic GBUS_RSRC_MEM = 1'b0;
  localparam logic GBUS_RSRC_RES = 1'b1;
endpackage

// File: rtl/obuf_fifo.sv
// obuf_fifo: synchronous result FIFO with registered full/almost_full/empty flags and occupancy
module obuf_fifo #(
  parameter int DW       = 64,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int AFULL_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT = (AW+1)'(DEPTH - AFULL_TH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, afull_q, afull_d, empty_q, empty_d;
  // next pointers, occupancy and flags derived from the post-update occupancy
  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = (push && !pop) ? cnt_q + 1'b1 : (!push && pop) ? cnt_q - 1'b1 : cnt_q;
    full_d  = cnt_d == FULL_CNT;
    afull_d = cnt_d >= AFULL_CNT;
    empty_d = cnt_d == '0;
  end
  // pointer, occupancy and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      empty_q <= empty_d;
    end
  end
  // storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end
  assign rdata       = mem_q[rptr_q];
  assign full        = full_q;
  assign almost_full = afull_q;
  assign empty       = empty_q;
  assign count       = cnt_q;
endmodule

// File: rtl/core_out_arb.sv
// core_out_arb: result FIFO + GBUS return arbitration (memory wins) + job word counter; OBUF_BYPASS_EN enables empty-FIFO bypass
module core_out_arb
  import core_out_pkg::*;
#(
  parameter int GBUS_DATA  = 64,
  parameter int OBUF_DEPTH = 8,
  parameter int OBUF_ADDR  = $clog2(OBUF_DEPTH),
  parameter int AFULL_TH   = 2,
  parameter int CNT_BIT    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [CNT_BIT-1:0]   cfg_out_num,
  input  logic [GBUS_DATA-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  input  logic [GBUS_DATA-1:0] res_wdata,
  input  logic                 res_wvalid,
  input  logic                 gbus_grant,
  output logic [GBUS_DATA-1:0] gbus_rdata,
  output logic                 gbus_rvalid,
  output logic                 gbus_rsrc,
  output logic                 obuf_full,
  output logic                 obuf_almost_full,
  output logic                 obuf_empty,
  output logic                 obuf_ovf,
  output logic                 out_done
);
  logic                 pop, byp, push, drop, issue;
  logic                 fifo_full, fifo_afull, fifo_empty;
  logic [OBUF_ADDR:0]   occ;
  logic [GBUS_DATA-1:0] head;
  logic [GBUS_DATA-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d, rsrc_q, rsrc_d, ovf_q, ovf_d;
  state_e               state_q, state_d;
  logic [CNT_BIT-1:0]   target_q, target_d, sent_q, sent_d;

  obuf_fifo #(
    .DW       (GBUS_DATA),
    .DEPTH    (OBUF_DEPTH),
    .AW       (OBUF_ADDR),
    .AFULL_TH (AFULL_TH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .wdata       (res_wdata),
    .rdata       (head),
    .full        (fifo_full),
    .almost_full (fifo_afull),
    .empty       (fifo_empty),
    .count       (occ)
  );

`ifdef OBUF_BYPASS_EN
  // an empty FIFO lets a granted result skip straight to the output register
  always_comb byp = fifo_empty && res_wvalid && !mem_rvalid && gbus_grant;
`else
  // every result word is staged through the FIFO
  always_comb byp = 1'b0;
`endif

  // arbitration: memory read data always wins, results drain only on grant
  always_comb begin
    pop      = !fifo_empty && !mem_rvalid && gbus_grant;
    issue    = pop || byp;
    push     = res_wvalid && !byp && (!fifo_full || pop);
    drop     = res_wvalid && !byp && !pop && occ[OBUF_ADDR];
    ovf_d    = (cfg_start ? 1'b0 : ovf_q) || drop;
    rvalid_d = mem_rvalid || issue;
    rsrc_d   = mem_rvalid ? GBUS_RSRC_MEM : issue ? GBUS_RSRC_RES : rsrc_q;
    rdata_d  = mem_rvalid ? mem_rdata : pop ? head : byp ? res_wdata : rdata_q;
  end

  // job FSM: start loads target, each issued result counts, last word ends the job
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sent_d   = sent_q;
    if (cfg_start && state_q != DONE) begin
      target_d = cfg_out_num;
      sent_d   = '0;
      state_d  = cfg_out_num == '0 ? DONE : RUN;
    end else if (state_q == RUN && issue && sent_q != target_q) begin
      sent_d  = sent_q + 1'b1;
      state_d = sent_d == target_q ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  // output register, overflow flag and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= GBUS_RSRC_MEM;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      target_q <= '0;
      sent_q   <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      target_q <= target_d;
      sent_q   <= sent_d;
    end
  end

  assign gbus_rdata       = rdata_q;
  assign gbus_rvalid      = rvalid_q;
  assign gbus_rsrc        = rsrc_q;
  assign obuf_full        = fifo_full;
  assign obuf_almost_full = fifo_afull;
  assign obuf_empty       = fifo_empty;
  assign obuf_ovf         = ovf_q;
  assign out_done         = state_q == DONE;
endmodule

// File: tb/tb_core_out_arb.sv
// tb_core_out_arb: directed self-checking bench for core_out_arb
module tb_core_out_arb;
  logic        clk = 1'b0;
  logic        rst, cfg_start, mem_rvalid, res_wvalid, gbus_grant;
  logic [11:0] cfg_out_num;
  logic [63:0] mem_rdata, res_wdata, gbus_rdata;
  logic        gbus_rvalid, gbus_rsrc, obuf_full, obuf_almost_full, obuf_empty, obuf_ovf, out_done;
  int          n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  core_out_arb dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_out_num      (cfg_out_num),
    .mem_rdata        (mem_rdata),
    .mem_rvalid       (mem_rvalid),
    .res_wdata        (res_wdata),
    .res_wvalid       (res_wvalid),
    .gbus_grant       (gbus_grant),
    .gbus_rdata       (gbus_rdata),
    .gbus_rvalid      (gbus_rvalid),
    .gbus_rsrc        (gbus_rsrc),
    .obuf_full        (obuf_full),
    .obuf_almost_full (obuf_almost_full),
    .obuf_empty       (obuf_empty),
    .obuf_ovf         (obuf_ovf),
    .out_done         (out_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdata"}, gbus_rdata, 64'h0);
    chk({tag, "_rvalid"}, gbus_rvalid, 1'b0);
    chk({tag, "_rsrc"}, gbus_rsrc, 1'b0);
    chk({tag, "_empty"}, obuf_empty, 1'b1);
    chk({tag, "_full"}, obuf_full, 1'b0);
    chk({tag, "_afull"}, obuf_almost_full, 1'b0);
    chk({tag, "_ovf"}, obuf_ovf, 1'b0);
    chk({tag, "_done"}, out_done, 1'b0);
  endtask

  initial begin
    int got;
    rst = 1'b1; cfg_start = 1'b0; cfg_out_num = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    res_wvalid = 1'b0; res_wdata = '0; gbus_grant = 1'b0;
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;

    // three results drained under continuous grant
    gbus_grant = 1'b1; res_wvalid = 1'b1; res_wdata = 64'h11;
`ifdef OBUF_BYPASS_EN
    tick();
    chk("byp_v0", gbus_rvalid, 1'b1); chk("byp_d0", gbus_rdata, 64'h11); chk("byp_empty", obuf_empty, 1'b1);
    res_wdata = 64'h22; tick();
    chk("byp_d1", gbus_rdata, 64'h22); chk("byp_src", gbus_rsrc, 1'b1);
    res_wdata = 64'h33; tick();
    chk("byp_d2", gbus_rdata, 64'h33);
    res_wvalid = 1'b0; tick();
    chk("byp_idle", gbus_rvalid, 1'b0);
`else
    tick();
    chk("t1_lat", gbus_rvalid, 1'b0);
    res_wdata = 64'h22; tick();
    chk("t1_v0", gbus_rvalid, 1'b1); chk("t1_d0", gbus_rdata, 64'h11); chk("t1_src0", gbus_rsrc, 1'b1);
    res_wdata = 64'h33; tick();
    chk("t1_d1", gbus_rdata, 64'h22);
    res_wvalid = 1'b0; tick();
    chk("t1_v2", gbus_rvalid, 1'b1); chk("t1_d2", gbus_rdata, 64'h33);
    tick();
    chk("t1_idle", gbus_rvalid, 1'b0); chk("t1_empty", obuf_empty, 1'b1);
`endif
    gbus_grant = 1'b0;

    // job of 4 results with memory reads overlapping the drain
    cfg_out_num = 12'd4; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t2_nodone", out_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      res_wvalid = 1'b1; res_wdata = 64'hA1 + 64'(i); tick();
    end
    res_wvalid = 1'b0; gbus_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = 64'hB1 + 64'(i); tick();
      chk("t2_mv", gbus_rvalid, 1'b1); chk("t2_msrc", gbus_rsrc, 1'b0);
      chk("t2_md", gbus_rdata, 64'hB1 + 64'(i)); chk("t2_mdone", out_done, 1'b0);
    end
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_rv", gbus_rvalid, 1'b1); chk("t2_rsrc", gbus_rsrc, 1'b1);
      chk("t2_rd", gbus_rdata, 64'hA1 + 64'(i)); chk("t2_done", out_done, i == 3);
    end
    tick();
    chk("t2_after_done", out_done, 1'b0); chk("t2_after_v", gbus_rvalid, 1'b0);

    // overflow: 9 pushes into 8 slots with no grant
    gbus_grant = 1'b0;
    for (int i = 0; i < 9; i++) begin
      res_wvalid = 1'b1; res_wdata = 64'hD0 + 64'(i); tick();
      chk("t3_afull", obuf_almost_full, i >= 5);
      chk("t3_full", obuf_full, i >= 7);
      chk("t3_ovf", obuf_ovf, i == 8);
    end
    res_wvalid = 1'b0; gbus_grant = 1'b1; got = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (gbus_rvalid) begin
        chk("t3_data", gbus_rdata, 64'hD0 + 64'(got));
        got++;
      end
    end
    chk("t3_count", got, 8);
    chk("t3_empty", obuf_empty, 1'b1);
    chk("t3_ovf_sticky", obuf_ovf, 1'b1);
    gbus_grant = 1'b0;

    // zero-length job: done one cycle after start, no traffic, ovf cleared
    cfg_out_num = 12'd0; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    chk("t5_done", out_done, 1'b1); chk("t5_novalid", gbus_rvalid, 1'b0); chk("t5_ovf_clr", obuf_ovf, 1'b0);
    tick();
    chk("t5_done_end", out_done, 1'b0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      res_wvalid = 1'b1; res_wdata = 64'hE0 + 64'(i); tick();
    end
    chk("t4_full", obuf_full, 1'b1);
    res_wdata = 64'hE8; gbus_grant = 1'b1; tick(); res_wvalid = 1'b0;
    chk("t4_d0", gbus_rdata, 64'hE0); chk("t4_occ", dut.u_fifo.cnt_q, 8);
    chk("t4_full_kept", obuf_full, 1'b1); chk("t4_ovf", obuf_ovf, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t4_data", gbus_rdata, 64'hE1 + 64'(i));
    end
    chk("t4_empty", obuf_empty, 1'b1);
    gbus_grant = 1'b0;

    // reset mid-job with 5 words queued
    cfg_out_num = 12'd6; cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_wvalid = 1'b1; res_wdata = 64'hC0 + 64'(i); tick();
    end
    res_wvalid = 1'b0;
    chk("t6_queued", obuf_empty, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_reset("t6_rst");
    gbus_grant = 1'b1; got = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (gbus_rvalid) got++;
    end
    chk("t6_no_words", got, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
